// File: rtl/axil_reg_bridge_pkg.sv
// Shared response codes and helpers for the AXI4-Lite to register-bus bridge.
package axil_reg_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] err_to_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_reg_sync_fifo.sv
// Single-clock FIFO, registered or fall-through; overflow/underflow assertions
// are compiled in only when AXIL_REG_BRIDGE_ASSERT_EN is defined.
module axil_reg_sync_fifo #(
    parameter int unsigned DEPTH        = 2,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter type         T            = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic full_o,
    output logic empty_o,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_is_empty;
    logic w_bypass;
    logic w_pop;
    logic w_pop_mem;
    logic w_push;

    assign w_is_empty = (r_count == '0);
    assign w_bypass   = FALL_THROUGH && w_is_empty;
    assign full_o     = (r_count == FULL_CNT);
    assign empty_o    = w_is_empty && !(FALL_THROUGH && push_i);
    assign data_o     = w_bypass ? data_i : r_mem[r_rd_ptr];

    // A bypassed entry popped in the same cycle never touches storage.
    assign w_pop     = pop_i && !empty_o;
    assign w_pop_mem = w_pop && !w_bypass;
    assign w_push    = push_i && (!full_o || w_pop_mem) && !(w_bypass && w_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop_mem)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop_mem)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop_mem)
                r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the count guards every read, so reset only costs area.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data_i;
    end

`ifdef AXIL_REG_BRIDGE_ASSERT_EN
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));
`endif

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to single-outstanding register-bus master with round-robin
// read/write arbitration. Define AXIL_REG_BRIDGE_ASSERT_EN for simulation checks.
module axil_reg_bridge
    import axil_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 2,
    parameter int unsigned DECOUPLE_W   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output logic [1:0]              b_resp_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic                    reg_valid_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                    reg_write_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic                    reg_ready_i,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_error_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
    } req_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } wentry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  error;
    } rresp_t;

    logic                  w_wf_full, w_wf_empty, w_wf_push, w_wf_pop;
    wentry_t               w_wf_in, w_wf_head;
    logic                  w_af_full, w_af_empty, w_af_push, w_af_pop;
    logic [ADDR_WIDTH-1:0] w_af_head;
    logic                  w_bf_full, w_bf_empty, w_bf_push, w_bf_pop;
    logic                  w_bf_head;
    logic                  w_rf_full, w_rf_empty, w_rf_push, w_rf_pop;
    rresp_t                w_rf_in, w_rf_head;

    logic w_write_valid, w_read_valid, w_grant_write, w_hs;
    req_t w_req;
    logic r_prio_write, r_hold, r_grant_write;

    assign aw_ready_o = aw_valid_i && w_valid_i && !w_wf_full;
    assign w_ready_o  = aw_ready_o;
    assign w_wf_push  = aw_ready_o;
    assign w_wf_in    = '{addr: aw_addr_i, data: w_data_i, strb: w_strb_i};

    assign ar_ready_o = !w_af_full;
    assign w_af_push  = ar_valid_i && ar_ready_o;

    // Response space is reserved before issue, so a handshake can always push.
    assign w_write_valid = !w_wf_empty && !w_bf_full;
    assign w_read_valid  = !w_af_empty && !w_rf_full;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_grant_write = w_write_valid;
        if (r_hold)
            w_grant_write = r_grant_write;
        else if (w_write_valid && w_read_valid)
            w_grant_write = r_prio_write;
        w_req.write = w_grant_write;
        w_req.addr  = w_grant_write ? w_wf_head.addr : w_af_head;
    end

    assign reg_valid_o = w_write_valid || w_read_valid;
    assign reg_addr_o  = w_req.addr;
    assign reg_write_o = w_req.write;
    assign reg_wdata_o = w_wf_head.data;
    assign reg_wstrb_o = w_wf_head.strb;
    assign w_hs        = reg_valid_o && reg_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio_write  <= 1'b1;
            r_hold        <= 1'b0;
            r_grant_write <= 1'b0;
        end else begin
            r_hold        <= reg_valid_o && !reg_ready_i;
            r_grant_write <= w_grant_write;
            if (w_hs)
                r_prio_write <= !w_grant_write;
        end
    end

    assign w_wf_pop  = w_hs && w_grant_write;
    assign w_af_pop  = w_hs && !w_grant_write;
    assign w_bf_push = w_wf_pop;
    assign w_rf_push = w_af_pop;
    assign w_rf_in   = '{data: reg_rdata_i, error: reg_error_i};

    assign b_valid_o = !w_bf_empty;
    assign b_resp_o  = err_to_resp(w_bf_head);
    assign w_bf_pop  = b_valid_o && b_ready_i;

    assign r_valid_o = !w_rf_empty;
    assign r_data_o  = w_rf_head.data;
    assign r_resp_o  = err_to_resp(w_rf_head.error);
    assign w_rf_pop  = r_valid_o && r_ready_i;

    axil_reg_sync_fifo #(.DEPTH(BUFFER_DEPTH), .FALL_THROUGH(DECOUPLE_W == 0), .T(wentry_t)) u_wfifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .full_o(w_wf_full), .empty_o(w_wf_empty),
        .push_i(w_wf_push), .pop_i(w_wf_pop), .data_i(w_wf_in), .data_o(w_wf_head)
    );

    axil_reg_sync_fifo #(.DEPTH(BUFFER_DEPTH), .FALL_THROUGH(1'b0), .T(logic [ADDR_WIDTH-1:0])) u_arfifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .full_o(w_af_full), .empty_o(w_af_empty),
        .push_i(w_af_push), .pop_i(w_af_pop), .data_i(ar_addr_i), .data_o(w_af_head)
    );

    axil_reg_sync_fifo #(.DEPTH(BUFFER_DEPTH), .FALL_THROUGH(1'b0), .T(logic)) u_bfifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .full_o(w_bf_full), .empty_o(w_bf_empty),
        .push_i(w_bf_push), .pop_i(w_bf_pop), .data_i(reg_error_i), .data_o(w_bf_head)
    );

    axil_reg_sync_fifo #(.DEPTH(BUFFER_DEPTH), .FALL_THROUGH(1'b0), .T(rresp_t)) u_rfifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .full_o(w_rf_full), .empty_o(w_rf_empty),
        .push_i(w_rf_push), .pop_i(w_rf_pop), .data_i(w_rf_in), .data_o(w_rf_head)
    );

`ifdef AXIL_REG_BRIDGE_ASSERT_EN
    initial begin
        assert (BUFFER_DEPTH > 0) else $fatal(1, "BUFFER_DEPTH must be > 0");
        assert (ADDR_WIDTH > 0) else $fatal(1, "ADDR_WIDTH must be > 0");
        assert (DATA_WIDTH > 0) else $fatal(1, "DATA_WIDTH must be > 0");
        assert (DATA_WIDTH % 8 == 0) else $fatal(1, "DATA_WIDTH must be a multiple of 8");
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (reg_valid_o && !reg_ready_i) |=> ($stable(reg_addr_o) && $stable(reg_write_o)));
`endif

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-level transaction model of the bridge.
module tb_axil_reg_bridge;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] aw_addr_i;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic          w_valid_i;
    logic          w_ready_o;
    logic [1:0]    b_resp_o;
    logic          b_valid_o;
    logic          b_ready_i;
    logic [AW-1:0] ar_addr_i;
    logic          ar_valid_i;
    logic          ar_ready_o;
    logic [DW-1:0] r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_valid_o;
    logic          r_ready_i;
    logic          reg_valid_o;
    logic [AW-1:0] reg_addr_o;
    logic          reg_write_o;
    logic [DW-1:0] reg_wdata_o;
    logic [SW-1:0] reg_wstrb_o;
    logic          reg_ready_i;
    logic [DW-1:0] reg_rdata_i;
    logic          reg_error_i;

    always #5 clk_i = ~clk_i;

    axil_reg_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .DECOUPLE_W(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .reg_valid_o(reg_valid_o), .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
        .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
    );

    // Transaction model: pending requests and responses as plain queues.
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } wr_t;
    typedef struct { logic [DW-1:0] data; logic err; } rd_t;

    wr_t           m_wq[$];
    logic [AW-1:0] m_arq[$];
    logic          m_bq[$];
    rd_t           m_rq[$];
    bit            m_prio_write;
    bit            m_hold;
    bit            m_held_write;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_wq.delete();
        m_arq.delete();
        m_bq.delete();
        m_rq.delete();
        m_prio_write = 1'b1;
        m_hold       = 1'b0;
        m_held_write = 1'b0;
    endtask

    task automatic idle_inputs();
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
        aw_addr_i = '0; w_data_i = '0; w_strb_i = '0; ar_addr_i = '0;
        b_ready_i = 0; r_ready_i = 0;
        reg_ready_i = 0; reg_rdata_i = '0; reg_error_i = 0;
    endtask

    // Called at a negedge; returns at the next negedge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("rst_b_valid", b_valid_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_reg_valid", reg_valid_o, 0);
        check("rst_ar_ready", ar_ready_o, 1);
        check("rst_aw_ready", aw_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Compare every visible output against the model, then advance one clock.
    task automatic step();
        bit wv, rv, gw, exp_valid, aw_acc, ar_acc, hs, b_pop, r_pop;
        #1;
        wv     = (m_wq.size() > 0) && (m_bq.size() < DEPTH);
        rv     = (m_arq.size() > 0) && (m_rq.size() < DEPTH);
        if (m_hold)        gw = m_held_write;
        else if (wv && rv) gw = m_prio_write;
        else               gw = wv;
        exp_valid = wv || rv;
        aw_acc = aw_valid_i && w_valid_i && (m_wq.size() < DEPTH);
        ar_acc = ar_valid_i && (m_arq.size() < DEPTH);

        check("aw_ready", aw_ready_o, aw_acc);
        check("w_ready", w_ready_o, aw_acc);
        check("ar_ready", ar_ready_o, m_arq.size() < DEPTH);
        check("reg_valid", reg_valid_o, exp_valid);
        if (exp_valid) begin
            check("reg_write", reg_write_o, gw);
            check("reg_addr", reg_addr_o, gw ? m_wq[0].addr : m_arq[0]);
        end
        if (m_wq.size() > 0) begin
            check("reg_wdata", reg_wdata_o, m_wq[0].data);
            check("reg_wstrb", reg_wstrb_o, m_wq[0].strb);
        end
        check("b_valid", b_valid_o, m_bq.size() > 0);
        if (m_bq.size() > 0) check("b_resp", b_resp_o, m_bq[0] ? 2'b10 : 2'b00);
        check("r_valid", r_valid_o, m_rq.size() > 0);
        if (m_rq.size() > 0) begin
            check("r_data", r_data_o, m_rq[0].data);
            check("r_resp", r_resp_o, m_rq[0].err ? 2'b10 : 2'b00);
        end

        hs    = exp_valid && reg_ready_i;
        b_pop = (m_bq.size() > 0) && b_ready_i;
        r_pop = (m_rq.size() > 0) && r_ready_i;
        if (b_pop) void'(m_bq.pop_front());
        if (r_pop) void'(m_rq.pop_front());
        if (hs) begin
            if (gw) begin
                void'(m_wq.pop_front());
                m_bq.push_back(reg_error_i);
                m_prio_write = 1'b0;
            end else begin
                void'(m_arq.pop_front());
                m_rq.push_back('{reg_rdata_i, reg_error_i});
                m_prio_write = 1'b1;
            end
        end
        if (aw_acc) m_wq.push_back('{aw_addr_i, w_data_i, w_strb_i});
        if (ar_acc) m_arq.push_back(ar_addr_i);
        m_hold       = exp_valid && !reg_ready_i;
        m_held_write = gw;

        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Single write
        aw_valid_i = 1; w_valid_i = 1; aw_addr_i = 32'h10; w_data_i = 32'hDEADBEEF;
        w_strb_i = 4'hF; reg_ready_i = 1; reg_error_i = 0;
        step();
        aw_valid_i = 0; w_valid_i = 0;
        #1;
        check("t1_reg_addr", reg_addr_o, 32'h10);
        check("t1_reg_wdata", reg_wdata_o, 32'hDEADBEEF);
        check("t1_reg_write", reg_write_o, 1);
        step();
        #1;
        check("t1_b_valid", b_valid_o, 1);
        check("t1_b_resp", b_resp_o, 2'b00);
        b_ready_i = 1;
        step();
        b_ready_i = 0;

        // Single read with error
        ar_valid_i = 1; ar_addr_i = 32'h20; reg_rdata_i = 32'h12345678; reg_error_i = 1;
        step();
        ar_valid_i = 0;
        #1;
        check("t2_reg_addr", reg_addr_o, 32'h20);
        check("t2_reg_write", reg_write_o, 0);
        step();
        #1;
        check("t2_r_valid", r_valid_o, 1);
        check("t2_r_data", r_data_o, 32'h12345678);
        check("t2_r_resp", r_resp_o, 2'b10);
        r_ready_i = 1;
        step();
        r_ready_i = 0; reg_error_i = 0;

        // Back-to-back reads with R channel stalled
        for (int i = 0; i < 6; i++) begin
            ar_valid_i  = 1;
            ar_addr_i   = 32'h100 + 32'(4 * i);
            reg_rdata_i = $urandom;
            step();
        end
        #1;
        check("t3_ar_full", ar_ready_o, 0);
        check("t3_reg_idle", reg_valid_o, 0);
        check("t3_r_valid", r_valid_o, 1);
        ar_valid_i = 0; r_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            reg_rdata_i = $urandom;
            step();
        end
        #1;
        check("t3_r_drained", r_valid_o, 0);
        r_ready_i = 0;

        // AW without W is not accepted
        aw_valid_i = 1; w_valid_i = 0; aw_addr_i = 32'h40; w_data_i = $urandom; w_strb_i = 4'h3;
        #1;
        check("t4_aw_ready_low", aw_ready_o, 0);
        check("t4_w_ready_low", w_ready_o, 0);
        step();
        w_valid_i = 1;
        #1;
        check("t4_aw_ready_high", aw_ready_o, 1);
        step();
        aw_valid_i = 0; w_valid_i = 0; b_ready_i = 1;
        repeat (3) step();

        // Fresh reset: both pending, write first, stall, then alternate
        do_reset();
        b_ready_i = 1; r_ready_i = 1; reg_ready_i = 0;
        aw_valid_i = 1; w_valid_i = 1; ar_valid_i = 1;
        aw_addr_i = 32'h200; w_data_i = $urandom; w_strb_i = 4'hF; ar_addr_i = 32'h300;
        step();
        aw_addr_i = 32'h204; w_data_i = $urandom; ar_addr_i = 32'h304;
        step();
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_hold_addr", reg_addr_o, 32'h200);
            check("t6_hold_write", reg_write_o, 1);
            check("t6_no_b", b_valid_o, 0);
            step();
        end
        reg_ready_i = 1;
        #1; check("t5_g0_addr", reg_addr_o, 32'h200); check("t5_g0_write", reg_write_o, 1); step();
        #1; check("t5_g1_addr", reg_addr_o, 32'h300); check("t5_g1_write", reg_write_o, 0); step();
        #1; check("t5_g2_addr", reg_addr_o, 32'h204); check("t5_g2_write", reg_write_o, 1); step();
        #1; check("t5_g3_addr", reg_addr_o, 32'h304); check("t5_g3_write", reg_write_o, 0); step();

        // Randomized traffic with two back-pressure profiles
        for (int c = 0; c < 3000; c++) begin
            int bp;
            bp = (c < 1500) ? 30 : 75;
            aw_valid_i  = ($urandom_range(0, 99) < 50);
            w_valid_i   = ($urandom_range(0, 99) < 60);
            aw_addr_i   = $urandom;
            w_data_i    = $urandom;
            w_strb_i    = 4'($urandom);
            ar_valid_i  = ($urandom_range(0, 99) < 50);
            ar_addr_i   = $urandom;
            reg_ready_i = ($urandom_range(0, 99) < 60);
            reg_rdata_i = $urandom;
            reg_error_i = 1'($urandom_range(0, 1));
            b_ready_i   = ($urandom_range(0, 99) < bp);
            r_ready_i   = ($urandom_range(0, 99) < bp);
            step();
        end

        idle_inputs();
        reg_ready_i = 1; b_ready_i = 1; r_ready_i = 1;
        repeat (12) step();
        #1;
        check("end_b_idle", b_valid_o, 0);
        check("end_r_idle", r_valid_o, 0);
        check("end_reg_idle", reg_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
